dmem_bridge: RTL and testbench
==============================

// Module: dmem_bridge
// PURPOSE
//   Sits between rv32i_core's data port and ram_wrap. Turns core loads/stores into RAM byte-lane accesses.
//   Aligns and sign-extends load data, and decodes one memory-mapped display register.
//   Owns display-mode arbitration: snoops one RAM word and produces disp_data for seg7_ctrl.
//   All load data returns with a fixed 1-cycle latency.
// PARAMETERS
//   DISP_ADDR  32'h0000_0200  RAM byte address shown on display in display mode
//   MMIO_ADDR  32'hFFFF_0000  address of display register (not backed by RAM)
// PORTS
//   m_clock    in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   mode_disp  in   1   display mode, already 2-flop synchronized upstream
//   dmem_r     in   1   core load request, single-cycle strobe
//   dmem_w     in   1   core store request, single-cycle strobe
//   daddr      in   32  core byte address
//   wdata      in   32  core store data, right-justified
//   size       in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//   uns        in   1   1 = zero-extend load (LBU/LHU)
//   rdata      out  32  aligned, extended load data
//   rvalid     out  1   1-cycle pulse, rdata valid
//   misalign   out  1   1-cycle pulse, access rejected
//   ram_addr   out  32  word-aligned byte address to ram_wrap
//   ram_wdata  out  32  lane-replicated store data
//   ram_rden   out  4   read lane enables
//   ram_wren   out  4   write lane enables
//   ram_rdata  in   32  RAM data, valid the cycle after ram_rden
//   disp_data  out  32  value for seg7_ctrl
// BEHAVIOUR
//   Reset (async): rdata, rvalid, misalign, disp_data, display register and all pipeline flops go to 0.
//   RAM-side outputs are combinational and are 0 when no access is active.
//   Access qualification:
//     - misaligned = (size==01 & daddr[0]) | (size[1] & daddr[1:0]!=0)
//     - Misaligned access: no RAM enables, no register write.
//     - Misaligned load: rvalid=1 with rdata=0 at N+1.
//     - Misaligned access: misalign pulses at N+1.
//   dmem_r & dmem_w in the same cycle: the store executes and the load is dropped (no rvalid).
//   Store at cycle N, mode_disp=0, address != MMIO_ADDR:
//     - ram_addr = {daddr[31:2],2'b00}
//     - byte: ram_wdata = {4{wdata[7:0]}}, ram_wren = 4'b0001 << daddr[1:0]
//     - half: ram_wdata = {2{wdata[15:0]}}, ram_wren = daddr[1] ? 4'b1100 : 4'b0011
//     - word: ram_wdata = wdata, ram_wren = 4'b1111
//   Store to MMIO_ADDR: no RAM enables.
//     - Lanes merge into the display register at the clock edge ending cycle N, using the same lane mask.
//   Load at cycle N, mode_disp=0:
//     - RAM: ram_rden = 4'b1111. MMIO_ADDR: no RAM enables.
//     - Registered for N+1: lane offset, size, uns, MMIO hit.
//     - rvalid=1 at N+1.
//     - rdata selects the lane from ram_rdata (or the display register on MMIO hit).
//     - Byte/half are sign-extended unless uns=1.
//   rdata holds its value until the next rvalid; it is not cleared.
//   mode_disp=1:
//     - Core stores are dropped silently.
//     - Core loads return rvalid=1, rdata=0 at N+1.
//     - ram_addr = DISP_ADDR, ram_rden = 4'b1111 every cycle.
//     - disp_data <= ram_rdata each cycle (1-cycle lag after the address).
//   mode_disp=0: disp_data <= display register (1-cycle lag after a store).
//   mode_disp rising while a load is in flight (issued at N in mode 0): the load still completes at N+1 with RAM data.
//   Back-to-back loads each get rvalid, one per cycle, in order; there is no stall.
//   A load to MMIO_ADDR in the cycle after a store to it returns the new value.
// TESTING
//   Reset mid-traffic: assert rst_n=0 while rvalid=1 -> rdata, rvalid, misalign, disp_data all 0 immediately.
//   Store word 0x8081_7F01 @0x40, load byte @0x41 uns=0 -> rdata=0x0000_007F.
//     Load byte @0x43 uns=0 -> 0xFFFF_FF80; uns=1 -> 0x0000_0080.
//   Store half 0xBEEF @0x22 -> ram_wren=1100, ram_wdata=0xBEEF_BEEF.
//     Load half @0x22 -> 0xFFFF_BEEF at the next cycle.
//   Load word @0x06 -> no ram_rden, misalign=1 and rvalid=1, rdata=0 at N+1.
//     Store half @0x05 -> misalign=1, ram_wren=0.
//   Store word 0x0012_3456 to MMIO_ADDR, mode_disp=0 -> ram_wren=0, disp_data=0x0012_3456 after 2 edges.
//     Then set mode_disp=1 with RAM[0x200]=0xCAFE_0001 -> ram_addr=0x200, disp_data=0xCAFE_0001.
//   Simultaneous dmem_r=dmem_w=1 @0x80 with wdata=5 -> word written, no rvalid.
//     Load issued the cycle before mode_disp rises -> rvalid with correct RAM data.

Source files
------------

// File: rtl/dmem_bridge.sv
// ---------------------------------------------------------------------------
// dmem_bridge
//   Connects the rv32i_core data port to ram_wrap. It turns core loads and
//   stores into word-aligned RAM byte-lane accesses, aligns and sign-extends
//   load data, and decodes one memory-mapped display register. It also
//   arbitrates display mode: while mode_disp is high it snoops one RAM word
//   and forwards it to seg7_ctrl through disp_data.
//
//   Load data always returns exactly one cycle after the request.
//
// Ports
//   m_clock    in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   mode_disp  in   1   display mode (synchronized upstream)
//   dmem_r     in   1   core load strobe
//   dmem_w     in   1   core store strobe
//   daddr      in   32  core byte address
//   wdata      in   32  core store data, right-justified
//   size       in   2   00 byte, 01 half, 10/11 word
//   uns        in   1   zero-extend load when 1
//   rdata      out  32  aligned, extended load data
//   rvalid     out  1   rdata valid pulse
//   misalign   out  1   rejected-access pulse
//   ram_addr   out  32  word-aligned RAM byte address
//   ram_wdata  out  32  lane-replicated store data
//   ram_rden   out  4   RAM read lane enables
//   ram_wren   out  4   RAM write lane enables
//   ram_rdata  in   32  RAM read data, valid the cycle after ram_rden
//   disp_data  out  32  value for seg7_ctrl
// ---------------------------------------------------------------------------
module dmem_bridge #(
    parameter logic [31:0] DISP_ADDR = 32'h0000_0200,
    parameter logic [31:0] MMIO_ADDR = 32'hFFFF_0000
) (
    input  logic        m_clock,
    input  logic        rst_n,
    input  logic        mode_disp,
    input  logic        dmem_r,
    input  logic        dmem_w,
    input  logic [31:0] daddr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        misalign,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_rden,
    output logic [3:0]  ram_wren,
    input  logic [31:0] ram_rdata,
    output logic [31:0] disp_data
);

    // Byte-lane enables for an access of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] m;
        case (sz)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicate the right-justified store data across every lane it may land in.
    function automatic logic [31:0] lane_rep(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Expand a 4-bit lane mask into a 32-bit bit mask.
    function automatic logic [31:0] bit_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Pick the addressed lane(s) out of a word and extend to 32 bits.
    function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] sz, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   r = u ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = u ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    logic        mis;
    logic        mmio_hit;
    logic        st_ok;
    logic        ld_ok;
    logic [3:0]  wmask;
    logic [31:0] wrep;

    logic        vld_p1;
    logic        zero_p1;
    logic        mis_p1;
    logic [1:0]  off_p1;
    logic [1:0]  size_p1;
    logic        uns_p1;
    logic        mmio_p1;
    logic [31:0] disp_reg;
    logic [31:0] rdata_hold;
    logic [31:0] rdata_fmt;

    assign mis      = ((size == 2'b01) & daddr[0]) | (size[1] & (daddr[1:0] != 2'b00));
    assign mmio_hit = (daddr == MMIO_ADDR);
    // A simultaneous load is dropped in favour of the store.
    assign st_ok    = dmem_w & ~mis & ~mode_disp;
    assign ld_ok    = dmem_r & ~dmem_w & ~mis & ~mode_disp;
    assign wmask    = lane_mask(size, daddr[1:0]);
    assign wrep     = lane_rep(size, wdata);

    // ---- stage 0: request decode, RAM-side outputs (combinational) ----
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_rden  = '0;
        ram_wren  = '0;
        if (mode_disp) begin
            ram_addr = DISP_ADDR;
            ram_rden = 4'b1111;
        end else if (st_ok && !mmio_hit) begin
            ram_addr  = {daddr[31:2], 2'b00};
            ram_wdata = wrep;
            ram_wren  = wmask;
        end else if (ld_ok && !mmio_hit) begin
            ram_addr = {daddr[31:2], 2'b00};
            ram_rden = 4'b1111;
        end
    end

    // ---- stage 0 -> 1: register load context, display register, display output ----
    always_ff @(posedge m_clock or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            zero_p1    <= 1'b0;
            mis_p1     <= 1'b0;
            off_p1     <= 2'b00;
            size_p1    <= 2'b00;
            uns_p1     <= 1'b0;
            mmio_p1    <= 1'b0;
            disp_reg   <= '0;
            disp_data  <= '0;
            rdata_hold <= '0;
        end else begin
            vld_p1  <= dmem_r & ~dmem_w;
            // Rejected or display-mode loads still answer, but with zero data.
            zero_p1 <= mis | mode_disp;
            mis_p1  <= (dmem_r | dmem_w) & mis & ~mode_disp;
            off_p1  <= daddr[1:0];
            size_p1 <= size;
            uns_p1  <= uns;
            mmio_p1 <= mmio_hit;
            if (st_ok && mmio_hit) begin
                disp_reg <= (disp_reg & ~bit_mask(wmask)) | (wrep & bit_mask(wmask));
            end
            disp_data <= mode_disp ? ram_rdata : disp_reg;
            if (vld_p1) begin
                rdata_hold <= rdata_fmt;
            end
        end
    end

    // ---- stage 1: response; RAM data arrives this cycle, so format it directly ----
    assign rdata_fmt = zero_p1 ? 32'h0 :
                       load_align(mmio_p1 ? disp_reg : ram_rdata, off_p1, size_p1, uns_p1);
    assign rdata     = vld_p1 ? rdata_fmt : rdata_hold;
    assign rvalid    = vld_p1;
    assign misalign  = mis_p1;

endmodule

// File: tb/tb_dmem_bridge.sv
module tb_dmem_bridge;

    localparam logic [31:0] MMIO = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode_disp;
    logic        dmem_r;
    logic        dmem_w;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rdata;
    logic        rvalid;
    logic        misalign;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_rden;
    logic [3:0]  ram_wren;
    logic [31:0] ram_rdata;
    logic [31:0] disp_data;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rv;
        logic        mis;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    dmem_bridge dut (
        .m_clock   (clk),
        .rst_n     (rst_n),
        .mode_disp (mode_disp),
        .dmem_r    (dmem_r),
        .dmem_w    (dmem_w),
        .daddr     (daddr),
        .wdata     (wdata),
        .size      (size),
        .uns       (uns),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .misalign  (misalign),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rden  (ram_rden),
        .ram_wren  (ram_wren),
        .ram_rdata (ram_rdata),
        .disp_data (disp_data)
    );

    // Behavioural ram_wrap: registered read, byte-lane write.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr[11:2]];
        if (ram_wren != 4'b0000) begin
            mem[ram_addr[11:2]] <= (mem[ram_addr[11:2]] &
                ~{{8{ram_wren[3]}}, {8{ram_wren[2]}}, {8{ram_wren[1]}}, {8{ram_wren[0]}}}) |
                (ram_wdata &
                {{8{ram_wren[3]}}, {8{ram_wren[2]}}, {8{ram_wren[1]}}, {8{ram_wren[0]}}});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Drive one request cycle; returns shortly after the inputs settle.
    task automatic op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic u, input logic md);
        @(posedge clk);
        #1;
        dmem_r    = r;
        dmem_w    = w;
        daddr     = a;
        wdata     = wd;
        size      = sz;
        uns       = u;
        mode_disp = md;
        #1;
    endtask

    task automatic idle(input logic md);
        op(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, md);
    endtask

    task automatic expect_load(input logic [31:0] d);
        sb.push_back('{rv: 1'b1, mis: 1'b0, rd: d});
    endtask

    // Monitor: every response pulse pops one expected event.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (rvalid || misalign)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response rvalid=%0d misalign=%0d rdata=0x%08h",
                         rvalid, misalign, rdata);
            end else begin
                e = sb.pop_front();
                chk("resp_rvalid", {31'b0, rvalid}, {31'b0, e.rv});
                chk("resp_misalign", {31'b0, misalign}, {31'b0, e.mis});
                if (e.rv) chk("resp_rdata", rdata, e.rd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst_n = 1'b0; mode_disp = 1'b0; dmem_r = 1'b0; dmem_w = 1'b0;
        daddr = '0; wdata = '0; size = 2'b10; uns = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_rvalid", {31'b0, rvalid}, 32'h0);
        chk("reset_misalign", {31'b0, misalign}, 32'h0);
        chk("reset_disp", disp_data, 32'h0);
        chk("idle_wren", {28'b0, ram_wren}, 32'h0);
        rst_n = 1'b1;

        // Word store, then byte loads with sign / zero extension.
        op(1'b0, 1'b1, 32'h40, 32'h8081_7F01, 2'b10, 1'b0, 1'b0);
        chk("stw_wren", {28'b0, ram_wren}, 32'hF);
        chk("stw_wdata", ram_wdata, 32'h8081_7F01);
        chk("stw_addr", ram_addr, 32'h40);
        op(1'b1, 1'b0, 32'h41, 32'h0, 2'b00, 1'b0, 1'b0);
        chk("ldb_rden", {28'b0, ram_rden}, 32'hF);
        chk("ldb_addr", ram_addr, 32'h40);
        expect_load(32'h0000_007F);
        op(1'b1, 1'b0, 32'h43, 32'h0, 2'b00, 1'b0, 1'b0);
        expect_load(32'hFFFF_FF80);
        op(1'b1, 1'b0, 32'h43, 32'h0, 2'b00, 1'b1, 1'b0);
        expect_load(32'h0000_0080);
        idle(1'b0);
        idle(1'b0);
        chk("rdata_hold", rdata, 32'h0000_0080);

        // Half store / load.
        op(1'b0, 1'b1, 32'h22, 32'h1234_BEEF, 2'b01, 1'b0, 1'b0);
        chk("sth_wren", {28'b0, ram_wren}, 32'hC);
        chk("sth_wdata", ram_wdata, 32'hBEEF_BEEF);
        chk("sth_addr", ram_addr, 32'h20);
        op(1'b1, 1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 1'b0);
        expect_load(32'hFFFF_BEEF);

        // Byte store merges into an existing word.
        op(1'b0, 1'b1, 32'h41, 32'h0000_00A5, 2'b00, 1'b0, 1'b0);
        chk("stb_wren", {28'b0, ram_wren}, 32'h2);
        chk("stb_wdata", ram_wdata, 32'hA5A5_A5A5);
        op(1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 1'b0);
        expect_load(32'h8081_A501);

        // Misaligned accesses.
        op(1'b1, 1'b0, 32'h06, 32'h0, 2'b10, 1'b0, 1'b0);
        chk("mis_ld_rden", {28'b0, ram_rden}, 32'h0);
        sb.push_back('{rv: 1'b1, mis: 1'b1, rd: 32'h0});
        op(1'b0, 1'b1, 32'h05, 32'hFFFF, 2'b01, 1'b0, 1'b0);
        chk("mis_st_wren", {28'b0, ram_wren}, 32'h0);
        sb.push_back('{rv: 1'b0, mis: 1'b1, rd: 32'h0});

        // Display register via MMIO.
        op(1'b0, 1'b1, MMIO, 32'h0012_3456, 2'b10, 1'b0, 1'b0);
        chk("mmio_wren", {28'b0, ram_wren}, 32'h0);
        chk("mmio_rden", {28'b0, ram_rden}, 32'h0);
        idle(1'b0);
        idle(1'b0);
        chk("mmio_disp", disp_data, 32'h0012_3456);
        op(1'b0, 1'b1, MMIO, 32'h0000_0077, 2'b00, 1'b0, 1'b0);
        op(1'b1, 1'b0, MMIO, 32'h0, 2'b10, 1'b0, 1'b0);
        expect_load(32'h0012_3477);
        op(1'b1, 1'b0, MMIO, 32'h0, 2'b00, 1'b0, 1'b0);
        expect_load(32'h0000_0077);

        // Simultaneous load and store: store wins, no response.
        op(1'b1, 1'b1, 32'h80, 32'h5, 2'b10, 1'b0, 1'b0);
        chk("rw_wren", {28'b0, ram_wren}, 32'hF);
        chk("rw_wdata", ram_wdata, 32'h5);
        chk("rw_rden", {28'b0, ram_rden}, 32'h0);
        op(1'b1, 1'b0, 32'h80, 32'h0, 2'b10, 1'b0, 1'b0);
        expect_load(32'h5);

        // Display mode: in-flight load completes, stores dropped, loads zero.
        op(1'b0, 1'b1, 32'h200, 32'hCAFE_0001, 2'b10, 1'b0, 1'b0);
        op(1'b1, 1'b0, 32'h80, 32'h0, 2'b10, 1'b0, 1'b0);
        expect_load(32'h5);
        idle(1'b1);
        chk("disp_addr", ram_addr, 32'h200);
        chk("disp_rden", {28'b0, ram_rden}, 32'hF);
        op(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1);
        chk("disp_st_wren", {28'b0, ram_wren}, 32'h0);
        op(1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 1'b1);
        expect_load(32'h0);
        idle(1'b1);
        idle(1'b1);
        chk("disp_snoop", disp_data, 32'hCAFE_0001);
        idle(1'b0);
        op(1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 1'b0);
        expect_load(32'h8081_A501);
        idle(1'b0);
        idle(1'b0);
        chk("disp_mode0", disp_data, 32'h0012_3477);

        // Reset while a response is on the outputs (not queued: it is wiped).
        op(1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 1'b0);
        idle(1'b0);
        chk("pre_rst_rvalid", {31'b0, rvalid}, 32'h1);
        chk("pre_rst_rdata", rdata, 32'h8081_A501);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_rvalid", {31'b0, rvalid}, 32'h0);
        chk("midrst_misalign", {31'b0, misalign}, 32'h0);
        chk("midrst_disp", disp_data, 32'h0);
        #2;
        rst_n = 1'b1;
        idle(1'b0);
        idle(1'b0);
        chk("post_rst_disp", disp_data, 32'h0);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
